parity: RTL and testbench

- Registered parity generator for a narrow data bus.
- Every rising clock edge it samples `data` and registers the XOR-reduction (even-parity bit) on `out`.
- Used as a per-word parity tag alongside a data path; one-cycle latency, no handshake.

---
 rtl/parity.sv | 24 ++
 tb/tb_parity.sv | 135 +++++++++++++
 2 files changed

// File: rtl/parity.sv
// Registered parity generator: samples data every rising edge and registers
// its XOR-reduction, optionally inverted for odd parity.
module parity #(
  parameter int unsigned WIDTH      = 4,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] data,
  output logic             out
);

  localparam bit Sense = ODD_PARITY;

  // X/Z on data deliberately propagates through the reduction to out.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out <= 1'b0;
    end else begin
      out <= (^data) ^ Sense;
    end
  end

endmodule

// File: tb/tb_parity.sv
// Directed bench for parity: even/odd sense, WIDTH 4/8/1, latency and async reset.
`timescale 1ns/1ps
module tb_parity;

  logic       clk;
  logic       n_rst;
  logic [3:0] data_e;
  logic [3:0] data_o;
  logic [7:0] data_w;
  logic [0:0] data_1;
  logic       out_e;
  logic       out_o;
  logic       out_w;
  logic       out_1;

  int unsigned total;
  int unsigned passed;

  parity #(.WIDTH(4), .ODD_PARITY(1'b0)) u_even (
    .clk(clk), .n_rst(n_rst), .data(data_e), .out(out_e)
  );
  parity #(.WIDTH(4), .ODD_PARITY(1'b1)) u_odd (
    .clk(clk), .n_rst(n_rst), .data(data_o), .out(out_o)
  );
  parity #(.WIDTH(8), .ODD_PARITY(1'b0)) u_wide (
    .clk(clk), .n_rst(n_rst), .data(data_w), .out(out_w)
  );
  parity #(.WIDTH(1), .ODD_PARITY(1'b0)) u_one (
    .clk(clk), .n_rst(n_rst), .data(data_1), .out(out_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] par_tbl;
    par_tbl = 16'h6996;  // bit i = parity of i, hand-computed
    total  = 0;
    passed = 0;

    // Reset held with nonzero data: all outputs stay 0.
    n_rst  = 1'b0;
    data_e = 4'b0111;
    data_o = 4'b0000;
    data_w = 8'h80;
    data_1 = 1'b1;
    #1;
    check("rst_even_t0", out_e, 1'b0);
    check("rst_odd_t0", out_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_even_hold", out_e, 1'b0);
      check("rst_odd_hold", out_o, 1'b0);
      check("rst_wide_hold", out_w, 1'b0);
      check("rst_one_hold", out_1, 1'b0);
    end

    // Release mid-cycle, away from any edge.
    @(negedge clk);
    n_rst  = 1'b1;
    data_e = 4'b0000;

    // Even-parity directed sequence.
    step(); check("even_0000_a", out_e, 1'b0);
    check("odd_0000", out_o, 1'b1);
    check("wide_80", out_w, 1'b1);
    check("one_1", out_1, 1'b1);
    data_o = 4'b0001; data_w = 8'hFF; data_1 = 1'b0;
    step(); check("even_0000_b", out_e, 1'b0);
    check("odd_0001", out_o, 1'b0);
    check("wide_ff", out_w, 1'b0);
    check("one_0", out_1, 1'b0);
    data_e = 4'b0010; data_w = 8'hA7;
    step(); check("even_0010", out_e, 1'b1);
    check("wide_a7", out_w, 1'b1);
    data_e = 4'b0011;
    step(); check("even_0011", out_e, 1'b0);
    data_e = 4'b0111;
    step(); check("even_0111", out_e, 1'b1);

    // Latency: a mid-cycle change must not reach out before the next edge.
    data_e = 4'b0000;
    step(); check("lat_pre", out_e, 1'b0);
    @(negedge clk);
    data_e = 4'b0001;
    #1; check("lat_hold", out_e, 1'b0);
    step(); check("lat_update", out_e, 1'b1);

    // Exhaustive sweep against the hand table.
    for (int v = 0; v < 16; v++) begin
      data_e = 4'(v);
      step();
      check($sformatf("sweep_%0d", v), out_e, par_tbl[v]);
    end

    // Mid-cycle async reset with out_e = 1 and out_o = 1.
    data_e = 4'b0111;
    data_o = 4'b0000;
    step();
    check("pre_rst_even", out_e, 1'b1);
    check("pre_rst_odd", out_o, 1'b1);
    #2;
    n_rst = 1'b0;
    #1;
    check("async_rst_even", out_e, 1'b0);
    check("async_rst_odd", out_o, 1'b0);
    step(); check("rst_hold_edge", out_e, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    step(); check("resume_even", out_e, 1'b1);
    check("resume_odd", out_o, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
